// File: rtl/jtcps1_obj_scan.sv
// jtcps1_obj_scan: per-line object table scanner.
// Walks the object table for the line in vrender, finds the entries that
// cover that line and hands one 16x16 tile request at a time to the draw engine.
// Optional feature macro: JTCPS1_OBJ_BLOCK_EN. When it is defined, an entry may
// describe a block of tiles (height/width from attr). When it is undefined,
// every entry is a single 16x16 tile.
//
// Handshake: start is a request strobe. It is high only while idle=1, and then
// for exactly one cycle per tile. The draw engine accepts the tile on any cycle
// where start=1. Because start already includes idle, every start is a transfer.
// obj_code/obj_attr/obj_hpos/obj_bank are registered and do not change while
// a request is pending.
module jtcps1_obj_scan #(
    parameter logic [7:0] MAX_TILES = 8'd160,
    parameter logic [7:0] END_CODE  = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        line_start,
    input  logic [8:0]  vrender,
    input  logic [1:0]  cfg_bank,
    output logic [9:0]  tbl_addr,
    input  logic [15:0] tbl_data,
    output logic [15:0] obj_code,
    output logic [15:0] obj_attr,
    output logic [8:0]  obj_hpos,
    output logic [1:0]  obj_bank,
    output logic        start,
    input  logic        idle,
    output logic        done,
    output logic        ovf,
    output logic [2:0]  dbg_state
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_ISSUE = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [7:0]  entry_q, entry_d;
    logic [2:0]  wcnt_q, wcnt_d;
    logic [9:0]  tbl_addr_q, tbl_addr_d;
    logic [8:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic [15:0] code_q, code_d;
    logic [15:0] attr_q, attr_d;
    logic [8:0]  vrender_q, vrender_d;
    logic [1:0]  bank_q, bank_d;
    logic [3:0]  row_q, row_d;
    logic [3:0]  vsub_q, vsub_d;
    logic [3:0]  col_q, col_d;
    logic        hcnt_q, hcnt_d;
    logic [7:0]  tile_cnt_q, tile_cnt_d;
    logic        ovf_q, ovf_d;
    logic [15:0] obj_code_q, obj_code_d;
    logic [15:0] obj_attr_q, obj_attr_d;
    logic [8:0]  obj_hpos_q, obj_hpos_d;

    logic [3:0]  hgt, wid;
    logic        vflip, hflip;
    logic [8:0]  dy, lim;
    logic        hit;
    logic [3:0]  row_chk, vsub_chk;
    logic [3:0]  req_row, req_vsub, req_col, code_col;
    logic        load_req, advance, start_int;

    // A request is only offered while the draw engine is idle; a new line
    // pre-empts a pending request.
    assign start_int = (state_q == ST_ISSUE) && idle && !line_start;

    assign start     = start_int;
    assign done      = (state_q == ST_DONE);
    assign ovf       = ovf_q;
    assign tbl_addr  = tbl_addr_q;
    assign obj_code  = obj_code_q;
    assign obj_attr  = obj_attr_q;
    assign obj_hpos  = obj_hpos_q;
    assign obj_bank  = bank_q;
    assign dbg_state = state_q;

    // Entry geometry and vertical hit test on the captured entry.
    always_comb begin
`ifdef JTCPS1_OBJ_BLOCK_EN
        hgt = attr_q[15:12];
        wid = attr_q[11:8];
`else
        hgt = 4'd0;
        wid = 4'd0;
`endif
        vflip    = attr_q[6];
        hflip    = attr_q[5];
        dy       = vrender_q - y_q;
        lim      = {1'b0, hgt, 4'b0000} + 9'd16;
        hit      = (dy < lim);
        row_chk  = vflip ? (hgt - dy[7:4]) : dy[7:4];
        vsub_chk = dy[3:0] ^ {4{vflip}};
    end

    // Next-state logic: fetch, check, issue/hold loop, plus line_start override.
    always_comb begin
        state_d    = state_q;
        entry_d    = entry_q;
        wcnt_d     = wcnt_q;
        tbl_addr_d = tbl_addr_q;
        x_d        = x_q;
        y_d        = y_q;
        code_d     = code_q;
        attr_d     = attr_q;
        vrender_d  = vrender_q;
        bank_d     = bank_q;
        row_d      = row_q;
        vsub_d     = vsub_q;
        col_d      = col_q;
        hcnt_d     = hcnt_q;
        tile_cnt_d = tile_cnt_q;
        ovf_d      = ovf_q;
        load_req   = 1'b0;
        advance    = 1'b0;
        req_row    = row_q;
        req_vsub   = vsub_q;
        req_col    = col_q;

        case (state_q)
            ST_FETCH: begin
                // Table data lags the address by one cycle: word k-1 is
                // captured while word k is being addressed.
                case (wcnt_q)
                    3'd1:    x_d    = tbl_data[8:0];
                    3'd2:    y_d    = tbl_data[8:0];
                    3'd3:    code_d = tbl_data;
                    3'd4:    attr_d = tbl_data;
                    default: ;
                endcase
                if (wcnt_q == 3'd4) begin
                    state_d = ST_CHECK;
                end else begin
                    wcnt_d = wcnt_q + 3'd1;
                    if (wcnt_q != 3'd3) begin
                        tbl_addr_d = {entry_q, wcnt_d[1:0]};
                    end
                end
            end
            ST_CHECK: begin
                if (attr_q[15:8] == END_CODE) begin
                    state_d = ST_DONE;
                end else if (hit) begin
                    row_d    = row_chk;
                    vsub_d   = vsub_chk;
                    col_d    = 4'd0;
                    req_row  = row_chk;
                    req_vsub = vsub_chk;
                    req_col  = 4'd0;
                    load_req = 1'b1;
                    state_d  = ST_ISSUE;
                end else begin
                    advance = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (start_int) begin
                    tile_cnt_d = tile_cnt_q + 8'd1;
                    hcnt_d     = 1'b0;
                    if (tile_cnt_d == MAX_TILES) begin
                        ovf_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!hcnt_q) begin
                    hcnt_d = 1'b1;
                end else if (col_q == wid) begin
                    advance = 1'b1;
                end else begin
                    col_d    = col_q + 4'd1;
                    req_col  = col_q + 4'd1;
                    load_req = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            default: ;
        endcase

        // Move to the next entry; leaving entry 255 ends the table.
        if (advance) begin
            if (entry_q == 8'hFF) begin
                state_d = ST_DONE;
            end else begin
                entry_d    = entry_q + 8'd1;
                tbl_addr_d = {entry_q + 8'd1, 2'b00};
                wcnt_d     = 3'd0;
                state_d    = ST_FETCH;
            end
        end

        code_col   = hflip ? (wid - req_col) : req_col;
        obj_code_d = load_req ? (code_q + {8'd0, req_row, 4'd0} + {12'd0, code_col}) : obj_code_q;
        obj_hpos_d = load_req ? (x_q + {1'b0, req_col, 4'd0}) : obj_hpos_q;
        obj_attr_d = load_req ? {attr_q[15:12], req_vsub, attr_q[7:0]} : obj_attr_q;

        // A new line restarts the scan from any state.
        if (line_start) begin
            vrender_d  = vrender;
            bank_d     = cfg_bank;
            tile_cnt_d = 8'd0;
            ovf_d      = 1'b0;
            entry_d    = 8'd0;
            wcnt_d     = 3'd0;
            tbl_addr_d = 10'd0;
            state_d    = ST_FETCH;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            entry_q    <= 8'd0;
            wcnt_q     <= 3'd0;
            tbl_addr_q <= 10'd0;
            x_q        <= 9'd0;
            y_q        <= 9'd0;
            code_q     <= 16'd0;
            attr_q     <= 16'd0;
            vrender_q  <= 9'd0;
            bank_q     <= 2'd0;
            row_q      <= 4'd0;
            vsub_q     <= 4'd0;
            col_q      <= 4'd0;
            hcnt_q     <= 1'b0;
            tile_cnt_q <= 8'd0;
            ovf_q      <= 1'b0;
            obj_code_q <= 16'd0;
            obj_attr_q <= 16'd0;
            obj_hpos_q <= 9'd0;
        end else begin
            state_q    <= state_d;
            entry_q    <= entry_d;
            wcnt_q     <= wcnt_d;
            tbl_addr_q <= tbl_addr_d;
            x_q        <= x_d;
            y_q        <= y_d;
            code_q     <= code_d;
            attr_q     <= attr_d;
            vrender_q  <= vrender_d;
            bank_q     <= bank_d;
            row_q      <= row_d;
            vsub_q     <= vsub_d;
            col_q      <= col_d;
            hcnt_q     <= hcnt_d;
            tile_cnt_q <= tile_cnt_d;
            ovf_q      <= ovf_d;
            obj_code_q <= obj_code_d;
            obj_attr_q <= obj_attr_d;
            obj_hpos_q <= obj_hpos_d;
        end
    end

endmodule

// File: doc/jtcps1_obj_scan.md
JTCPS1_OBJ_SCAN -- requirements
Module: jtcps1_obj_scan

Interface
REQ-001 SHALL have parameter MAX_TILES, default 8'd160, tile draw requests allowed per line.
REQ-002 SHALL have parameter END_CODE, default 8'hFF, attr[15:8] value marking end of table.
REQ-003 clk  in  1  sole clock, all logic rising-edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 line_start  in  1  one-cycle pulse: begin scanning the table for vrender.
REQ-006 vrender  in  9  line being prepared, sampled on line_start.
REQ-007 cfg_bank  in  2  ROM bank, sampled on line_start.
REQ-008 tbl_addr  out  10  object table word address {entry[7:0], word[1:0]}.
REQ-009 tbl_data  in  16  table word, valid exactly 1 cycle after tbl_addr changes.
REQ-010 obj_code/obj_attr  out  16/16, obj_hpos  out  9, obj_bank  out  2, start  out  1: draw-engine request.
REQ-011 idle  in  1  draw engine ready; it samples a request only when start=1 and idle=1.
REQ-012 done  out  1  high from scan completion until next line_start.
REQ-013 ovf  out  1  high if MAX_TILES was reached on this line.

Function
REQ-014 Entry layout: word0 x[8:0], word1 y[8:0], word2 code, word3 attr (attr[15:12] height-1, [11:8] width-1, [6] vflip, [5] hflip, [4:0] palette).
REQ-015 States: IDLE, FETCH, CHECK, ISSUE, HOLD, DONE; reset into IDLE with done=0.
REQ-016 line_start in any state SHALL latch vrender/cfg_bank, clear tile count, ovf and done, set entry=0 and enter FETCH next cycle; it wins over every other event.
REQ-017 FETCH SHALL drive the four words of the entry in order, capturing each one cycle later (5 cycles per entry).
REQ-018 In CHECK, attr[15:8]==END_CODE or entry wrap 255->0 SHALL enter DONE.
REQ-019 dy = vrender - y, 9-bit modulo; hit when dy < 16*(height+1); miss SHALL advance to next entry (FETCH).
REQ-020 On hit: row = dy[7:4], replaced by height-row when vflip; vsub = dy[3:0] XOR {4{vflip}}.
REQ-021 ISSUE iterates col 0..width; obj_hpos = x + 16*col (9-bit wrap); code column = hflip ? width-col : col.
REQ-022 obj_code = code + 16*row + code column (16-bit wrap); obj_attr = attr with [11:8] replaced by vsub; obj_bank = latched cfg_bank.
REQ-023 start SHALL assert only while idle=1, for exactly one cycle per tile, with request outputs stable that cycle.
REQ-024 After each start SHALL enter HOLD for 2 cycles, ignoring idle, then resume ISSUE.
REQ-025 Tile count increments per start; on reaching MAX_TILES SHALL set ovf and enter DONE.
REQ-026 After last column, next entry; hpos filtering is left to the draw engine.
REQ-027 DONE SHALL hold done=1, start=0 until line_start.

Reset
REQ-028 On rst: start=0, done=0, ovf=0, tbl_addr=0, obj_code=0, obj_attr=0, obj_hpos=0, obj_bank=0, counters 0, state IDLE.
REQ-029 rst mid-scan SHALL abort immediately; no start after release until line_start.

Configuration
REQ-030 Macro JTCPS1_OBJ_BLOCK_EN defined: multi-tile blocks per REQ-019..022.
REQ-031 Undefined: height and width treated as 0 (single 16x16 tile); END_CODE check still uses raw attr[15:8].

Verification
REQ-032 Entry0 x=0x40,y=0x20,code=0x100,attr=0x0003, vrender=0x25 -> one start, code 0x100, attr 0x0503, hpos 0x40, then done.
REQ-033 Same, attr=0x0140 (width 2, vflip), vrender=0x22 -> starts code 0x100/0x101, hpos 0x40/0x50, attr[11:8]=0xD.
REQ-034 attr=0x1020 (height 2, hflip), y=0x20, vrender=0x31 -> one start code 0x110, vsub 1; macro off -> no start.
REQ-035 idle held 0 for 20 cycles during ISSUE -> no start until idle=1, outputs stable, no request lost.
REQ-036 200 hit entries, MAX_TILES=160 -> exactly 160 starts, ovf=1, done=1.
REQ-037 line_start mid-ISSUE -> scan restarts at entry 0 next cycle, ovf=0; rst mid-FETCH -> start stays 0.
